regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//   Parametrised multi-port integer register file for the pipelined core. Provides NUM_RD
//   combinational read ports and two write ports, both with same-cycle write-through bypass.
//   Adds a per-register pending scoreboard for hazard detection in decode, and a handshaked
//   debug dump engine that streams every register out, for syscall and trace checking.
// PARAMETERS
//   DATA_W    32  register width in bits
//   NUM_REGS  32  number of registers; power of two, >= 2
//   ADDR_W    5   log2(NUM_REGS)
//   NUM_RD    2   number of read ports, >= 1
//   ZERO_REG  1   1: reg 0 reads 0, ignores writes, and is never pending
// PORTS
//   clk       in   1               clock; all state updates on posedge
//   rst       in   1               asynchronous, active-low reset
//   rd_addr   in   NUM_RD*ADDR_W   read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
//   rd_data   out  NUM_RD*DATA_W   read data, combinational, packed the same way
//   rd_pend   out  NUM_RD          pending bit of each read address, after bypass
//   we0/we1   in   1               write enables, port 0 = ALU writeback, port 1 = load/mul
//   wa0/wa1   in   ADDR_W          write addresses
//   wd0/wd1   in   DATA_W          write data
//   iss_valid in   1               issue: mark iss_addr pending
//   iss_addr  in   ADDR_W          destination register of the issuing instruction
//   dump_req  in   1               start-dump pulse
//   dump_valid out 1               dump beat valid
//   dump_ready in  1               consumer accepts the beat
//   dump_addr out  ADDR_W          register index of the current beat
//   dump_data out  DATA_W          register value of the current beat
//   dump_busy out  1               dump engine not IDLE
//   dump_done out  1               one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//   Reset (rst=0, async): all registers 0, all pending bits 0, FSM IDLE, dump_valid=0,
//     dump_busy=0, dump_done=0, dump_addr=0. A reset mid-dump aborts the dump with no done pulse.
//   Write: on posedge, weN && waN!=0 (or ZERO_REG=0) stores wdN. Both ports to the same
//     address in one cycle: port 1 wins.
//   Read: rd_data[k] = wd1 if we1 && wa1==addr; else wd0 if we0 && wa0==addr; else the array.
//     Address 0 with ZERO_REG=1 always reads 0, including during bypass.
//   Scoreboard: iss_valid sets pend[iss_addr]; weN clears pend[waN].
//     Set and clear of the same address in one cycle: set wins (newer producer).
//     rd_pend[k] = pend[addr] && !(write this cycle to addr && !(iss_valid && iss_addr==addr)).
//   Dump FSM:
//     IDLE: dump_req -> DUMP, with idx=0.
//     DUMP: dump_valid=1, dump_addr=idx, dump_data = bypassed read of idx.
//       On valid&&ready: idx==NUM_REGS-1 -> DONE, else idx+1.
//       While ready=0, dump_addr is held; dump_data tracks live writes.
//     DONE: dump_done=1 for one cycle, then IDLE.
//     dump_req outside IDLE is ignored. dump_busy=1 in DUMP and DONE.
//     Normal reads and writes are never stalled by the dump.
//   No wrap beyond NUM_REGS-1; idx width is ADDR_W.
// TESTING
//   1 Reset: rst=0 mid-run -> every rd_data 0, rd_pend 0, dump_busy 0, no done pulse.
//   2 we0 wa0=5 wd0=0xDEADBEEF with rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF
//     combinationally; array holds 0xDEADBEEF on the next cycle.
//   3 we0 and we1 both to reg 7 (0x11, 0x22) -> bypass and stored value both 0x22;
//     write 0x55 to reg 0 -> reads 0.
//   4 iss_valid addr 9 -> next cycle rd_pend=1 for reg 9; then iss and we1 to reg 9 in one
//     cycle -> stays pending; we0 to reg 9 alone -> pending clears.
//   5 Dump, NUM_REGS=32, regs preset to 0x100+i, ready toggling 1/0 -> 32 beats, addr 0..31,
//     data 0x100+addr, dump_done exactly one cycle after beat 31 is accepted.
//   6 NUM_RD=3, DATA_W=64 build: write regs 1..3 with distinct values, read all three ports
//     -> correct packed output; reset asserted at beat 10 of a dump -> IDLE, no done pulse.

Source files
------------

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write-through bypass, a per-register pending
// scoreboard for decode hazard checks, and a handshaked debug dump engine.
module regfile_mp_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     dump_req,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_busy,
    output logic                     dump_done
);
    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic [ADDR_W-1:0]   idx;
    logic                wr0, wr1;

    assign wr0 = we0 && (ZERO_REG == 0 || wa0 != '0);
    assign wr1 = we1 && (ZERO_REG == 0 || wa1 != '0);

    // Port 1 has priority over port 0 on a same-address collision.
    function automatic logic [DATA_W-1:0] byp_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        if (ZERO_REG != 0 && a == '0)  r = '0;
        else if (we1 && wa1 == a)      r = wd1;
        else if (we0 && wa0 == a)      r = wd0;
        else                           r = regs[a];
        return r;
    endfunction

    // A write this cycle retires the pending producer unless a newer one issues now.
    function automatic logic byp_pend(input logic [ADDR_W-1:0] a);
        logic hit_w, hit_i;
        hit_w = (we0 && wa0 == a) || (we1 && wa1 == a);
        hit_i = iss_valid && iss_addr == a;
        return pend[a] && !(hit_w && !hit_i);
    endfunction

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        always_comb begin
            rd_data[k*DATA_W +: DATA_W] = byp_read(rd_addr[k*ADDR_W +: ADDR_W]);
            rd_pend[k]                  = byp_pend(rd_addr[k*ADDR_W +: ADDR_W]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (wr0) regs[wa0] <= wd0;
            if (wr1) regs[wa1] <= wd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (iss_valid && iss_addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0))
                    pend[i] <= 1'b1;
                else if ((we0 && wa0 == ADDR_W'(i)) || (we1 && wa1 == ADDR_W'(i)))
                    pend[i] <= 1'b0;
            end
        end
    end

    assign dump_addr = idx;
    assign dump_data = byp_read(idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: if (dump_req) begin
                    state      <= DUMP;
                    idx        <= '0;
                    dump_valid <= 1'b1;
                    dump_busy  <= 1'b1;
                end
                DUMP: if (dump_ready) begin
                    if (idx == ADDR_W'(NUM_REGS - 1)) begin
                        state      <= DONE;
                        dump_valid <= 1'b0;
                        dump_done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    idx       <= '0;
                    dump_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Self-checking bench: directed read/write/scoreboard checks plus a queued dump scoreboard,
// on a default build and on a 3-read-port 64-bit build.
module tb_regfile_mp_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // default build
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        we0, we1, iss_valid, dump_req, dump_ready;
    logic [4:0]  wa0, wa1, iss_addr, dump_addr;
    logic [31:0] wd0, wd1, dump_data;
    logic        dump_valid, dump_busy, dump_done;

    // 3-port 64-bit build
    logic [14:0]  w_rd_addr;
    logic [191:0] w_rd_data;
    logic [2:0]   w_rd_pend;
    logic         w_we0, w_we1, w_iss_valid, w_dump_req, w_dump_ready;
    logic [4:0]   w_wa0, w_wa1, w_iss_addr, w_dump_addr;
    logic [63:0]  w_wd0, w_wd1, w_dump_data;
    logic         w_dump_valid, w_dump_busy, w_dump_done;

    regfile_mp_scoreboard u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .dump_req(dump_req),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
    );

    regfile_mp_scoreboard #(.DATA_W(64), .NUM_RD(3)) u_wide (
        .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_pend(w_rd_pend),
        .we0(w_we0), .wa0(w_wa0), .wd0(w_wd0), .we1(w_we1), .wa1(w_wa1), .wd1(w_wd1),
        .iss_valid(w_iss_valid), .iss_addr(w_iss_addr), .dump_req(w_dump_req),
        .dump_valid(w_dump_valid), .dump_ready(w_dump_ready), .dump_addr(w_dump_addr),
        .dump_data(w_dump_data), .dump_busy(w_dump_busy), .dump_done(w_dump_done)
    );

    typedef struct { logic [4:0] a; logic [31:0] d; } beat_t;
    beat_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        we0 = 0; we1 = 0; iss_valid = 0; dump_req = 0; dump_ready = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_addr = 0;
        w_we0 = 0; w_we1 = 0; w_iss_valid = 0; w_dump_req = 0; w_dump_ready = 0;
        w_wa0 = 0; w_wa1 = 0; w_wd0 = 0; w_wd1 = 0; w_iss_addr = 0;
    endtask

    initial begin
        int beats, early_done, late_done;
        beat_t b;

        rst = 0; quiet(); rd_addr = '0; w_rd_addr = '0;
        tick(); tick();
        rst = 1;
        #1;
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_pend", 64'(rd_pend), 64'h0);
        chk("rst_busy", 64'(dump_busy), 64'h0);
        chk("rst_valid", 64'(dump_valid), 64'h0);
        chk("rst_done", 64'(dump_done), 64'h0);
        chk("rst_dump_addr", 64'(dump_addr), 64'h0);

        // write-through bypass then stored value
        tick();
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
        #1 chk("byp_wr0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        tick(); quiet();
        #1 chk("stored_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);

        // both ports to reg 7: port 1 wins
        we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; rd_addr = {5'd7, 5'd5};
        #1 chk("byp_dual_r7", 64'(rd_data[63:32]), 64'h22);
        tick(); quiet();
        #1 chk("stored_dual_r7", 64'(rd_data[63:32]), 64'h22);
        chk("r5_untouched", 64'(rd_data[31:0]), 64'hDEADBEEF);

        // reg 0 ignores writes, including on the bypass path
        we0 = 1; wa0 = 0; wd0 = 32'h55; rd_addr = {5'd7, 5'd0};
        #1 chk("byp_r0", 64'(rd_data[31:0]), 64'h0);
        tick(); quiet();
        #1 chk("stored_r0", 64'(rd_data[31:0]), 64'h0);

        // scoreboard
        iss_valid = 1; iss_addr = 9; rd_addr = {5'd8, 5'd9};
        #1 chk("pend_before_set", 64'(rd_pend[0]), 64'h0);
        tick(); quiet();
        #1 chk("pend_r9_set", 64'(rd_pend[0]), 64'h1);
        chk("pend_r8_clear", 64'(rd_pend[1]), 64'h0);
        iss_valid = 1; iss_addr = 9; we1 = 1; wa1 = 9; wd1 = 32'h99;
        #1 chk("pend_set_wins_comb", 64'(rd_pend[0]), 64'h1);
        tick(); quiet();
        #1 chk("pend_set_wins_reg", 64'(rd_pend[0]), 64'h1);
        we0 = 1; wa0 = 9; wd0 = 32'h9A;
        #1 chk("pend_clear_byp", 64'(rd_pend[0]), 64'h0);
        tick(); quiet();
        #1 chk("pend_cleared", 64'(rd_pend[0]), 64'h0);
        iss_valid = 1; iss_addr = 0; rd_addr = {5'd0, 5'd0};
        tick(); quiet();
        #1 chk("pend_r0_never", 64'(rd_pend[0]), 64'h0);

        // preset 0x100+i and queue the expected dump beats
        for (int i = 1; i < 32; i += 2) begin
            we0 = 1; wa0 = 5'(i); wd0 = 32'h100 + 32'(i);
            we1 = (i + 1 < 32); wa1 = 5'(i + 1); wd1 = 32'h100 + 32'(i + 1);
            tick();
        end
        quiet();
        for (int i = 0; i < 32; i++) begin
            b.a = 5'(i);
            b.d = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
            exp_q.push_back(b);
        end
        dump_req = 1;
        tick(); dump_req = 0;
        beats = 0; early_done = 0;
        for (int cyc = 0; cyc < 200 && beats < 32; cyc++) begin
            dump_ready = (cyc % 2 == 0);
            dump_req = (cyc == 7);
            #1;
            if (dump_done) early_done++;
            if (dump_valid && dump_ready) begin
                b = exp_q.pop_front();
                chk("dump_addr", 64'(dump_addr), 64'(b.a));
                chk("dump_data", 64'(dump_data), 64'(b.d));
                beats++;
            end
            tick();
        end
        quiet();
        chk("dump_beats", 64'(beats), 64'd32);
        chk("dump_early_done", 64'(early_done), 64'h0);
        chk("dump_done_pulse", 64'(dump_done), 64'h1);
        chk("dump_busy_done", 64'(dump_busy), 64'h1);
        chk("dump_valid_done", 64'(dump_valid), 64'h0);
        tick();
        chk("dump_done_clear", 64'(dump_done), 64'h0);
        chk("dump_busy_clear", 64'(dump_busy), 64'h0);

        // wide build: packed reads across three ports
        w_we0 = 1; w_wa0 = 1; w_wd0 = 64'h1111_2222_3333_4444;
        w_we1 = 1; w_wa1 = 2; w_wd1 = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        w_we0 = 1; w_wa0 = 3; w_wd0 = 64'h0123_4567_89AB_CDEF; w_we1 = 0;
        tick(); quiet();
        w_rd_addr = {5'd3, 5'd2, 5'd1};
        #1;
        chk("wide_p0", w_rd_data[63:0], 64'h1111_2222_3333_4444);
        chk("wide_p1", w_rd_data[127:64], 64'hAAAA_BBBB_CCCC_DDDD);
        chk("wide_p2", w_rd_data[191:128], 64'h0123_4567_89AB_CDEF);

        // pend something on the default build so the reset has state to clear
        iss_valid = 1; iss_addr = 12; rd_addr = {5'd12, 5'd5};
        tick(); quiet();

        // abort a wide dump at beat 10 with an asynchronous reset
        w_dump_req = 1;
        tick(); w_dump_req = 0; w_dump_ready = 1;
        beats = 0;
        for (int cyc = 0; cyc < 100 && beats < 10; cyc++) begin
            #1;
            if (w_dump_valid && w_dump_ready) beats++;
            tick();
        end
        chk("wide_beat10_addr", 64'(w_dump_addr), 64'd10);
        chk("pend_r12_pre_rst", 64'(rd_pend[1]), 64'h1);
        #2 rst = 0;
        #1;
        chk("arst_w_busy", 64'(w_dump_busy), 64'h0);
        chk("arst_w_valid", 64'(w_dump_valid), 64'h0);
        chk("arst_w_addr", 64'(w_dump_addr), 64'h0);
        chk("arst_w_rd_p0", w_rd_data[63:0], 64'h0);
        chk("arst_rd_data", rd_data, 64'h0);
        chk("arst_rd_pend", 64'(rd_pend), 64'h0);
        chk("arst_busy", 64'(dump_busy), 64'h0);
        late_done = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 2) rst = 1;
            tick();
            if (w_dump_done || dump_done || w_dump_busy) late_done++;
        end
        chk("arst_no_done", 64'(late_done), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
